pump_sequencer: RTL and testbench
=================================

# pump_sequencer

Filter-cycle controller for the water treatment path. Takes the 4-bit water-quality status word delivered by the Pico handshake receiver and the raw float level sensor, and sequences the fill / return / drain cycle. Drives ramped duty commands to the two pump PWM generators and enforces fill/drain timeouts with a latched fault. Sits between the handshake receiver and the PWM generators in the `designer` top level.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before the synchronized level sensor is accepted (1 ms at 50 MHz).
- `RAMP_STEP_CYCLES`, 1024: cycles between successive +1 duty increments.
- `DUTY_RUN`, 8'd180: duty for both pumps in RETURNING.
- `FILL_TIMEOUT`, 500000000: maximum cycles in FILLING (10 s).
- `DRAIN_TIMEOUT`, 500000000: maximum cycles in DRAINING.

- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-low reset.
- `status_valid_in`  in  1  one-cycle pulse: new status word from the handshake receiver.
- `status_in`  in  4  anomaly flags, one per sensor; any bit set = bad water. Sampled only when `status_valid_in` = 1.
- `level_sensor_in`  in  1  raw, asynchronous float sensor: 1 = empty/dry, 0 = full/wet.
- `fault_clear_in`  in  1  level; leaves FAULT.
- `duty_a_out`  out  8  pump A (fill) duty command.
- `duty_b_out`  out  8  pump B (return/drain) duty command.
- `state_out`  out  3  current state encoding.
- `fault_out`  out  1  high while in FAULT.

## Operation
- Level path: 2-flop synchronizer, then debounce counter. The debounced level changes only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample resets the counter.
- `bad` = `status_valid_in` & (`status_in` != 0). `good` = `status_valid_in` & (`status_in` == 0).
- States and encodings:
  - IDLE=0
  - FILLING=1
  - RETURNING=2
  - DRAINING=3
  - FAULT=4
  - Unused encodings → IDLE.
- Pump targets (A/B) per state:
  - IDLE: 0/0
  - FILLING: 255/0
  - RETURNING: `DUTY_RUN`/`DUTY_RUN`
  - DRAINING: 0/255
  - FAULT: 0/0
- Transitions:
  - IDLE: `bad` → FILLING. If `pending` is set, go to FILLING immediately and clear `pending`.
  - FILLING: debounced level = 0 → RETURNING. Else timer = `FILL_TIMEOUT` → FAULT. Else `good` → DRAINING (abort).
  - RETURNING: `good` → DRAINING. `bad` → stay.
  - DRAINING: debounced level = 1 → IDLE. Else timer = `DRAIN_TIMEOUT` → FAULT. `bad` sets `pending` and the drain continues. `good` clears `pending`.
  - FAULT: `fault_clear_in` → IDLE, and `pending` is cleared. All status words are ignored in FAULT.
- Priority within a state: level event > timeout > status.
- State timer: 32-bit counter. Cleared on every state transition. Increments in FILLING and DRAINING. Saturates at all-ones.
- Duty ramp, per pump, independent:
  - If target < current, duty is loaded with the target on the next cycle (immediate, safety).
  - If target > current, duty rises by 1 every `RAMP_STEP_CYCLES` cycles and never exceeds the target.
  - The ramp prescaler clears on every state transition.

## Timing
- Reset (`reset`=0 at a `clk` edge) values:
  - state IDLE, `pending`=0, timer=0
  - debounced level=1, debounce counter=0
  - `duty_a_out`=`duty_b_out`=0, `fault_out`=0, `state_out`=0
- Reset mid-cycle has the same effect: duties drop to 0 on that edge.
- Outputs are registered. A `status_valid_in` pulse at edge N gives the new `state_out` after edge N+1.
- On a downward target change, duty reaches the target one cycle after the state changes.
- Upward ramp: first +1 lands `RAMP_STEP_CYCLES` cycles after entry. 0→255 takes 255·`RAMP_STEP_CYCLES` cycles.
- Sensor edge to state change: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- Timeout fires in the cycle the timer equals the limit. A level event in that same cycle wins.
- `status_valid_in` held for more than one cycle counts as repeated words; the behaviour must be idempotent.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `RAMP_STEP_CYCLES`=2, `DUTY_RUN`=8, `FILL_TIMEOUT`=`DRAIN_TIMEOUT`=200. `level_sensor_in`=1 unless stated.

1. Reset: hold `reset`=0 for 5 cycles with `level_sensor_in`=0 and `status_valid_in` pulsing. Required: state 0, duties 0, `fault_out`=0 throughout; after release, no transition until 7 cycles of stable level.
2. Full cycle:
   - pulse status 4'b0100 → state 1; `duty_a_out` steps 0,1,2… every 2 cycles.
   - level=0 → state 2 after 7 cycles; A drops immediately toward 8, B ramps to 8.
   - status 4'b0000 → state 3; A=0 next cycle, B ramps to 255.
   - level=1 → state 0; both duties 0.
3. Fill timeout: bad status, level kept 1 → state 4 and `fault_out`=1 exactly 200 cycles after FILLING entry; duties 0. Status 4'b1111 is ignored. `fault_clear_in` → state 0.
4. Simultaneous events: debounced level goes full in the same cycle the timer hits 200 → state 2, no fault. In a separate run, level bounces with period 3 (< debounce) → no transition.
5. Pending refill: in DRAINING send 4'b0001 → stays 3. On empty → IDLE for one cycle, then FILLING with no new status. Variant: 4'b0001 then 4'b0000 while draining → ends in IDLE.
6. Fill abort: in FILLING with `duty_a_out`=20, send 4'b0000 → state 3, `duty_a_out`=0 on the next cycle, B starts ramping.

Source files
------------

// File: rtl/pump_sequencer.sv
// Filter-cycle controller: debounces the float sensor, sequences
// fill / return / drain from the water-quality status word, ramps the two
// pump duty commands and latches a fault on fill/drain timeout.
module pump_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned RAMP_STEP_CYCLES = 1024,
    parameter logic [7:0]  DUTY_RUN         = 8'd180,
    parameter int unsigned FILL_TIMEOUT     = 500000000,
    parameter int unsigned DRAIN_TIMEOUT    = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       status_valid_in,
    input  logic [3:0] status_in,
    input  logic       level_sensor_in,
    input  logic       fault_clear_in,
    output logic [7:0] duty_a_out,
    output logic [7:0] duty_b_out,
    output logic [2:0] state_out,
    output logic       fault_out
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILLING   = 3'd1,
        RETURNING = 3'd2,
        DRAINING  = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RS_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RS_W-1:0] RS_LAST   = RS_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [31:0]     FILL_LIM  = FILL_TIMEOUT;
    localparam logic [31:0]     DRAIN_LIM = DRAIN_TIMEOUT;

    // Downward moves are immediate (safety); upward moves creep by one per step.
    function automatic logic [7:0] ramp_duty(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic       step);
        logic [7:0] res;
        res = cur;
        if (tgt < cur)
            res = tgt;
        else if ((tgt > cur) && step)
            res = cur + 8'd1;
        return res;
    endfunction

    // State timer saturates instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic            lvl_sync_p0;
    logic            lvl_sync_p1;
    logic            level_db;
    logic [DB_W-1:0] db_cnt;
    state_t          state;
    state_t          state_next;
    logic            pending;
    logic            pending_next;
    logic [31:0]     timer;
    logic [RS_W-1:0] presc;
    logic            ramp_tick;
    logic            changed;
    logic [7:0]      tgt_a;
    logic [7:0]      tgt_b;
    logic [7:0]      duty_a;
    logic [7:0]      duty_b;
    logic            fault_q;
    logic            bad;
    logic            good;

    assign bad       = status_valid_in && (status_in != 4'd0);
    assign good      = status_valid_in && (status_in == 4'd0);
    assign changed   = (state_next != state);
    assign ramp_tick = (presc == RS_LAST);

    // Two-flop synchronizer for the asynchronous float sensor; resets to "empty".
    always_ff @(posedge clk) begin
        if (!reset) begin
            lvl_sync_p0 <= 1'b1;
            lvl_sync_p1 <= 1'b1;
        end else begin
            lvl_sync_p0 <= level_sensor_in;
            lvl_sync_p1 <= lvl_sync_p0;
        end
    end

    // Debounce: accept the synchronized level after DEBOUNCE_CYCLES disagreeing cycles in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            level_db <= 1'b1;
            db_cnt   <= '0;
        end else if (lvl_sync_p1 == level_db) begin
            db_cnt   <= '0;
        end else if (db_cnt == DB_LAST) begin
            level_db <= lvl_sync_p1;
            db_cnt   <= '0;
        end else begin
            db_cnt   <= db_cnt + DB_W'(1);
        end
    end

    // Next-state and refill-request logic; level event beats timeout beats status.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_next   = FILLING;
                    pending_next = 1'b0;
                end else if (bad) begin
                    state_next = FILLING;
                end
            end
            FILLING: begin
                if (!level_db)
                    state_next = RETURNING;
                else if (timer == FILL_LIM)
                    state_next = FAULT;
                else if (good)
                    state_next = DRAINING;
            end
            RETURNING: begin
                if (good)
                    state_next = DRAINING;
            end
            DRAINING: begin
                if (level_db)
                    state_next = IDLE;
                else if (timer == DRAIN_LIM)
                    state_next = FAULT;
                else if (bad)
                    pending_next = 1'b1;
                else if (good)
                    pending_next = 1'b0;
            end
            FAULT: begin
                if (fault_clear_in) begin
                    state_next   = IDLE;
                    pending_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pump duty targets follow the registered state.
    always_comb begin
        tgt_a = 8'd0;
        tgt_b = 8'd0;
        case (state)
            FILLING:   tgt_a = 8'd255;
            RETURNING: begin
                tgt_a = DUTY_RUN;
                tgt_b = DUTY_RUN;
            end
            DRAINING:  tgt_b = 8'd255;
            default:   ;
        endcase
    end

    // State, refill request, fault flag and the per-state timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            fault_q <= 1'b0;
            timer   <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            fault_q <= (state_next == FAULT);
            if (changed)
                timer <= '0;
            else if ((state == FILLING) || (state == DRAINING))
                timer <= sat_inc32(timer);
        end
    end

    // Ramp prescaler and duty registers; prescaler restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc  <= '0;
            duty_a <= 8'd0;
            duty_b <= 8'd0;
        end else begin
            presc  <= (changed || ramp_tick) ? '0 : presc + RS_W'(1);
            duty_a <= ramp_duty(duty_a, tgt_a, ramp_tick);
            duty_b <= ramp_duty(duty_b, tgt_b, ramp_tick);
        end
    end

    assign duty_a_out = duty_a;
    assign duty_b_out = duty_b;
    assign state_out  = state;
    assign fault_out  = fault_q;

endmodule

// File: tb/tb_pump_sequencer.sv
// Bench for pump_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the filter cycle.
module tb_pump_sequencer;

    localparam int         DEB  = 4;
    localparam int         STEP = 2;
    localparam logic [7:0] RUN  = 8'd8;
    localparam int         TO   = 200;

    localparam int M_IDLE = 0, M_FILL = 1, M_RET = 2, M_DRAIN = 3, M_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       status_valid_in = 1'b0;
    logic [3:0] status_in = 4'd0;
    logic       level_sensor_in = 1'b1;
    logic       fault_clear_in = 1'b0;
    logic [7:0] duty_a_out;
    logic [7:0] duty_b_out;
    logic [2:0] state_out;
    logic       fault_out;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int     m_state;
    longint m_timer;
    int     m_age;
    int     m_da;
    int     m_dbv;
    bit     m_pending;
    bit     m_lvl;
    bit     m_fault;
    bit     m_sync [2];
    bit     m_hist [$];

    always #5 clk = ~clk;

    pump_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .RAMP_STEP_CYCLES(STEP),
        .DUTY_RUN        (RUN),
        .FILL_TIMEOUT    (TO),
        .DRAIN_TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .status_valid_in(status_valid_in),
        .status_in      (status_in),
        .level_sensor_in(level_sensor_in),
        .fault_clear_in (fault_clear_in),
        .duty_a_out     (duty_a_out),
        .duty_b_out     (duty_b_out),
        .state_out      (state_out),
        .fault_out      (fault_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT will sample at that edge.
    task automatic model_step();
        int nxt;
        int ta;
        int tb;
        bit bad;
        bit good;
        bit tick;
        bit all_diff;
        if (!reset) begin
            m_state = M_IDLE; m_pending = 0; m_timer = 0; m_age = 0;
            m_da = 0; m_dbv = 0; m_lvl = 1; m_fault = 0;
            m_sync[0] = 1; m_sync[1] = 1;
            m_hist.delete();
        end else begin
            bad  = status_valid_in && (status_in != 0);
            good = status_valid_in && (status_in == 0);
            nxt  = m_state;
            case (m_state)
                M_IDLE:  if (m_pending) begin nxt = M_FILL; m_pending = 0; end
                         else if (bad) nxt = M_FILL;
                M_FILL:  if (m_lvl == 0) nxt = M_RET;
                         else if (m_timer == TO) nxt = M_FAULT;
                         else if (good) nxt = M_DRAIN;
                M_RET:   if (good) nxt = M_DRAIN;
                M_DRAIN: if (m_lvl == 1) nxt = M_IDLE;
                         else if (m_timer == TO) nxt = M_FAULT;
                         else if (bad) m_pending = 1;
                         else if (good) m_pending = 0;
                M_FAULT: if (fault_clear_in) begin nxt = M_IDLE; m_pending = 0; end
                default: nxt = M_IDLE;
            endcase
            ta = (m_state == M_FILL) ? 255 : (m_state == M_RET) ? int'(RUN) : 0;
            tb = (m_state == M_DRAIN) ? 255 : (m_state == M_RET) ? int'(RUN) : 0;
            tick = ((m_age % STEP) == STEP - 1);
            if (ta < m_da) m_da = ta; else if (ta > m_da && tick) m_da++;
            if (tb < m_dbv) m_dbv = tb; else if (tb > m_dbv && tick) m_dbv++;
            if (nxt != m_state) begin
                m_timer = 0;
                m_age = 0;
            end else begin
                m_age++;
                if ((m_state == M_FILL || m_state == M_DRAIN) && m_timer < 64'hFFFF_FFFF)
                    m_timer++;
            end
            m_fault = (nxt == M_FAULT);
            m_state = nxt;
            // level accepted once the last DEB synchronized samples all disagree with it
            m_hist.push_back(m_sync[1]);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            all_diff = (m_hist.size() == DEB);
            foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 0;
            if (all_diff) begin
                m_lvl = !m_lvl;
                m_hist.delete();
            end
            m_sync[1] = m_sync[0];
            m_sync[0] = level_sensor_in;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", state_out, m_state);
        chk("duty_a", duty_a_out, m_da);
        chk("duty_b", duty_b_out, m_dbv);
        chk("fault", fault_out, m_fault);
    endtask

    task automatic pulse(input logic [3:0] s);
        status_valid_in = 1'b1;
        status_in = s;
        tick();
        status_valid_in = 1'b0;
        status_in = 4'd0;
    endtask

    task automatic wait_state(input string tag, input int target, input int budget, output int n);
        n = 0;
        while (state_out != 3'(target) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, state_out, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1. Reset held with level full and status pulsing
        reset = 1'b0;
        level_sensor_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            status_valid_in = (i % 2 == 0);
            status_in = 4'b0100;
            tick();
            chk("rst_state", state_out, 0);
            chk("rst_duty_a", duty_a_out, 0);
            chk("rst_duty_b", duty_b_out, 0);
            chk("rst_fault", fault_out, 0);
        end
        status_valid_in = 1'b0;
        status_in = 4'd0;
        reset = 1'b1;
        repeat (3) tick();
        level_sensor_in = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", state_out, 0);

        // 2. Full cycle
        pulse(4'b0100);
        chk("fill_entry", state_out, 1);
        repeat (20) tick();
        chk("fill_ramp", duty_a_out, 10);
        level_sensor_in = 1'b0;
        wait_state("ret_entry", M_RET, 20, n);
        chk("lvl_latency", n, 7);
        tick();
        chk("ret_a_drop", duty_a_out, RUN);
        repeat (30) tick();
        chk("ret_b_run", duty_b_out, RUN);
        pulse(4'b0000);
        chk("drain_entry", state_out, 3);
        tick();
        chk("drain_a_zero", duty_a_out, 0);
        repeat (20) tick();
        level_sensor_in = 1'b1;
        wait_state("drain_done", M_IDLE, 20, n);
        tick();
        chk("idle_duty_b", duty_b_out, 0);

        // 3. Fill timeout, ignored status in FAULT, clear
        pulse(4'b1000);
        wait_state("fill_timeout", M_FAULT, 300, n);
        chk("fault_flag", fault_out, 1);
        pulse(4'b1111);
        pulse(4'b0000);
        chk("fault_ignores", state_out, 4);
        chk("fault_duty_a", duty_a_out, 0);
        fault_clear_in = 1'b1;
        tick();
        fault_clear_in = 1'b0;
        chk("fault_clear", state_out, 0);

        // 4a. Level event in the same cycle as the fill timeout
        pulse(4'b0010);
        repeat (194) tick();
        level_sensor_in = 1'b0;
        wait_state("sim_ret", M_RET, 20, n);
        chk("sim_latency", n, 7);
        chk("sim_no_fault", fault_out, 0);
        pulse(4'b0000);
        level_sensor_in = 1'b1;
        wait_state("sim_idle", M_IDLE, 20, n);

        // 4b. Bouncing sensor never settles
        pulse(4'b0010);
        for (int i = 0; i < 60; i++) begin
            level_sensor_in = (i % 3 == 0);
            tick();
        end
        chk("bounce_hold", state_out, 1);
        level_sensor_in = 1'b1;
        pulse(4'b0000);
        wait_state("bounce_idle", M_IDLE, 20, n);

        // 5. Pending refill while draining
        pulse(4'b0100);
        level_sensor_in = 1'b0;
        wait_state("pend_ret", M_RET, 20, n);
        pulse(4'b0000);
        pulse(4'b0001);
        chk("pend_stay", state_out, 3);
        repeat (5) tick();
        level_sensor_in = 1'b1;
        wait_state("pend_idle", M_IDLE, 20, n);
        tick();
        chk("pend_refill", state_out, 1);
        level_sensor_in = 1'b0;
        wait_state("pend2_ret", M_RET, 20, n);
        pulse(4'b0000);
        pulse(4'b0001);
        pulse(4'b0000);
        level_sensor_in = 1'b1;
        wait_state("pend2_idle", M_IDLE, 20, n);
        repeat (5) tick();
        chk("pend_cleared", state_out, 0);

        // 6. Fill abort at duty 20, level goes full just as drain starts
        pulse(4'b0100);
        repeat (35) tick();
        level_sensor_in = 1'b0;
        repeat (5) tick();
        chk("abort_duty20", duty_a_out, 20);
        pulse(4'b0000);
        chk("abort_state", state_out, 3);
        tick();
        chk("abort_duty_a", duty_a_out, 0);
        repeat (10) tick();
        chk("abort_b_ramp", duty_b_out, 5);
        level_sensor_in = 1'b1;
        wait_state("abort_idle", M_IDLE, 20, n);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            status_valid_in = ($urandom_range(0, 5) == 0);
            status_in = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 19) == 0) level_sensor_in = ~level_sensor_in;
            fault_clear_in = ($urandom_range(0, 29) == 0);
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
